// File: rtl/xif_pkg.sv
// Shared CV-X-IF result types and sizing helpers.
// Holds x_result_t, source count limits and the index width helper.
package xif_pkg;

  localparam int unsigned X_ID_WIDTH     = 4;
  localparam int unsigned X_HARTID_WIDTH = 1;
  localparam int unsigned X_RFW_WIDTH    = 32;
  localparam int unsigned X_DUALWRITE    = 0;
  localparam int unsigned X_WE_WIDTH     =
    (X_DUALWRITE != 0) ? 2 : 1;

  localparam int unsigned NUM_SRC_MIN = 2;
  localparam int unsigned NUM_SRC_MAX = 16;

  typedef struct packed {
    logic [X_HARTID_WIDTH-1:0] hartid;
    logic [X_ID_WIDTH-1:0]     id;
    logic [X_RFW_WIDTH-1:0]    data;
    logic [4:0]                rd;
    logic [X_WE_WIDTH-1:0]     we;
    logic                      exc;
    logic [5:0]                exccode;
    logic                      dbg;
    logic                      err;
  } x_result_t;

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit num_src_ok(
    input int unsigned n
  );
    return (n >= NUM_SRC_MIN) && (n <= NUM_SRC_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: ptr is the top-priority request.
// Ports: req[N], ptr -> one-hot gnt, winner idx, any (winner exists).
module rr_arbiter
  import xif_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]  idx,
  output logic                  any
);

  localparam int unsigned IW = idx_w(N);
  localparam int unsigned SW = IW + 1;

  // s walks ptr, ptr+1, ... with a single modulo-N fold
  logic [SW-1:0] s;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + SW'(k);
      if (s >= SW'(N)) s = s - SW'(N);
      if (!any && req[s[IW-1:0]]) begin
        gnt[s[IW-1:0]] = 1'b1;
        idx            = s[IW-1:0];
        any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xif_result_arbiter.sv
// Merges NUM_SRC result streams onto one registered CV-X-IF result port.
// Ports: clk_i, rst_i, src_valid/ready/result, result_valid/ready/o, grant_idx_o.
module xif_result_arbiter
  import xif_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_SRC-1:0]            src_valid_i,
  output logic [NUM_SRC-1:0]            src_ready_o,
  input  x_result_t [NUM_SRC-1:0]       src_result_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output x_result_t                     result_o,
  output logic [idx_w(NUM_SRC)-1:0]     grant_idx_o
);

  localparam int unsigned IW = idx_w(NUM_SRC);

  logic             out_valid;
  x_result_t        out_result;
  logic [IW-1:0]    out_idx;
  logic [IW-1:0]    rr_ptr;

  logic [NUM_SRC-1:0] gnt;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               can_load;
  logic               accept;

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr (
    .req (src_valid_i),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign can_load = !out_valid || result_ready_i;
  assign accept   = can_load && win_any && !rst_i;

  assign src_ready_o = accept ? gnt : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_idx    <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= src_result_i[win_idx];
      out_idx    <= win_idx;
      rr_ptr     <= (win_idx == IW'(NUM_SRC - 1))
                  ? '0 : win_idx + 1'b1;
    end else if (result_ready_i) begin
      out_valid  <= 1'b0;
    end
  end

  // Gate with rst_i so outputs read zero for the whole reset window,
  // including the first cycle before any clock edge has cleared state.
  assign result_valid_o = out_valid && !rst_i;
  assign result_o       = rst_i ? '0 : out_result;
  assign grant_idx_o    = rst_i ? '0 : out_idx;

endmodule

// File: tb/tb_xif_result_arbiter.sv
// Scoreboard bench for xif_result_arbiter with directed vectors.
// Stimulus pushes expected results; a negedge monitor pops on handshake.
module tb_xif_result_arbiter;
  import xif_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] idx;
    x_result_t  res;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         src_valid;
  logic [N-1:0]         src_ready;
  x_result_t [N-1:0]    src_result;
  logic                 result_valid;
  logic                 result_ready;
  x_result_t            result;
  logic [1:0]           grant_idx;

  exp_t      sb[$];
  int        errors = 0;
  int        checks = 0;
  x_result_t p;
  logic [3:0] all1 = 4'b1111;

  always #5 clk = ~clk;

  xif_result_arbiter #(
    .NUM_SRC (N)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .src_valid_i    (src_valid),
    .src_ready_o    (src_ready),
    .src_result_i   (src_result),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_o       (result),
    .grant_idx_o    (grant_idx)
  );

  function automatic x_result_t mk(input logic [3:0] id);
    x_result_t r;
    r      = '0;
    r.id   = id;
    r.data = 32'hA500_0000 | {28'h0, id};
    r.rd   = 5'(id) + 5'd1;
    r.we   = '1;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] i,
                      input x_result_t r);
    exp_t e;
    e.idx = i;
    e.res = r;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on handshake, plus hold-until-taken check.
  logic      prev_hold = 1'b0;
  x_result_t prev_res;
  logic [1:0] prev_idx;

  always @(negedge clk) begin
    if (prev_hold && !rst) begin
      chk("hold_valid", 64'(result_valid), 64'(1));
      chk("hold_result", 64'(result), 64'(prev_res));
      chk("hold_idx", 64'(grant_idx), 64'(prev_idx));
    end
    if (result_valid && result_ready && !rst) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got idx %0d id %0h, expected none",
                 grant_idx, result.id);
      end else begin
        chk("sb_idx", 64'(grant_idx), 64'(sb[0].idx));
        chk("sb_result", 64'(result), 64'(sb[0].res));
        void'(sb.pop_front());
      end
    end
    prev_hold <= result_valid && !result_ready && !rst;
    prev_res  <= result;
    prev_idx  <= grant_idx;
  end

  // Source-side protocol: valid and payload held until ready.
  logic [N-1:0]      pend = '0;
  x_result_t [N-1:0] pres;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pend[i] && !rst)
        assert (src_valid[i] && src_result[i] == pres[i])
          else $error("source %0d dropped or changed before ready", i);
    end
    pend <= src_valid & ~src_ready & {N{~rst}};
    pres <= src_result;
  end

  initial begin
    rst          = 1'b1;
    src_valid    = 4'b1111;
    result_ready = 1'b0;
    for (int i = 0; i < N; i++) src_result[i] = mk(4'(4 + i));

    // reset held 3 cycles with all sources requesting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 64'(src_ready), 64'(0));
      chk("rst_valid", 64'(result_valid), 64'(0));
      chk("rst_idx", 64'(grant_idx), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      step();
    end
    rst          = 1'b0;
    result_ready = 1'b1;

    // fairness: 0,1,2,3,0,1,2,3; each source drops after its last grant
    for (int c = 0; c < 8; c++) begin
      src_valid = all1 << ((c >= 4) ? (c - 4) : 0);
      push(2'(c % 4), mk(4'(4 + c % 4)));
      @(negedge clk);
      chk("fair_ready", 64'(src_ready), 64'(4'b0001 << (c % 4)));
      step();
    end
    src_valid = '0;
    @(negedge clk);
    chk("fair_last_valid", 64'(result_valid), 64'(1));
    step();
    @(negedge clk);
    chk("fair_idle_valid", 64'(result_valid), 64'(0));
    chk("fair_ptr", 64'(dut.rr_ptr), 64'(0));
    step();

    // back-pressure: source 2 id=5 held for 4 stalled cycles
    result_ready  = 1'b0;
    src_result[2] = mk(4'd5);
    src_valid     = 4'b0100;
    push(2'd2, mk(4'd5));
    @(negedge clk);
    chk("bp_grant", 64'(src_ready), 64'(4'b0100));
    step();
    src_result[0] = mk(4'd9);
    src_valid     = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_ready", 64'(src_ready), 64'(0));
      chk("bp_valid", 64'(result_valid), 64'(1));
      chk("bp_idx", 64'(grant_idx), 64'(2));
      chk("bp_id", 64'(result.id), 64'(5));
      step();
    end
    result_ready = 1'b1;
    push(2'd0, mk(4'd9));
    @(negedge clk);
    chk("bp_drain_grant", 64'(src_ready), 64'(4'b0001));
    step();
    src_valid = '0;
    @(negedge clk);
    chk("bp_no_bubble", 64'(result_valid), 64'(1));
    chk("bp_next_idx", 64'(grant_idx), 64'(0));
    step();
    @(negedge clk);
    chk("bp_idle", 64'(result_valid), 64'(0));
    step();

    // sparse: source 3 then source 1; pointer wraps after 3
    src_result[3] = mk(4'd12);
    src_valid     = 4'b1000;
    push(2'd3, mk(4'd12));
    @(negedge clk);
    chk("sp_grant3", 64'(src_ready), 64'(4'b1000));
    step();
    src_result[1] = mk(4'd1);
    src_valid     = 4'b0010;
    push(2'd1, mk(4'd1));
    @(negedge clk);
    chk("sp_wrap_ptr", 64'(dut.rr_ptr), 64'(0));
    chk("sp_grant1", 64'(src_ready), 64'(4'b0010));
    step();
    src_valid = '0;
    @(negedge clk);
    step();

    // payload passthrough from source 1
    p         = '0;
    p.hartid  = 1'b1;
    p.id      = 4'd3;
    p.data    = 32'hDEADBEEF;
    p.rd      = 5'd7;
    p.we      = '0;
    p.exc     = 1'b1;
    p.exccode = 6'd13;
    p.dbg     = 1'b1;
    p.err     = 1'b1;
    src_result[1] = p;
    src_valid     = 4'b0010;
    push(2'd1, p);
    @(negedge clk);
    chk("pt_grant", 64'(src_ready), 64'(4'b0010));
    step();
    src_valid = '0;
    @(negedge clk);
    chk("pt_exccode", 64'(result.exccode), 64'(13));
    chk("pt_data", 64'(result.data), 64'(32'hDEADBEEF));
    chk("pt_exc_we", 64'({result.exc, result.we}), 64'(2'b10));
    step();
    @(negedge clk);
    step();

    // reset mid-flight: held result discarded, pointer cleared
    result_ready  = 1'b0;
    src_result[2] = mk(4'd12);
    src_valid     = 4'b0100;
    @(negedge clk);
    chk("rf_grant", 64'(src_ready), 64'(4'b0100));
    step();
    src_valid = '0;
    @(negedge clk);
    chk("rf_valid", 64'(result_valid), 64'(1));
    chk("rf_idx", 64'(grant_idx), 64'(2));
    chk("rf_ptr_pre", 64'(dut.rr_ptr), 64'(3));
    step();
    rst           = 1'b1;
    src_result[0] = mk(4'd10);
    src_valid     = 4'b0001;
    @(negedge clk);
    chk("rf_rst_ready", 64'(src_ready), 64'(0));
    chk("rf_rst_valid", 64'(result_valid), 64'(0));
    step();
    rst = 1'b0;
    push(2'd0, mk(4'd10));
    @(negedge clk);
    chk("rf_post_valid", 64'(result_valid), 64'(0));
    chk("rf_post_idx", 64'(grant_idx), 64'(0));
    chk("rf_post_ptr", 64'(dut.rr_ptr), 64'(0));
    chk("rf_post_grant", 64'(src_ready), 64'(4'b0001));
    step();
    src_valid    = '0;
    result_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xif_result_arbiter.md
# xif_result_arbiter

Coprocessor-side arbiter that merges the result streams of `NUM_SRC` functional units onto the single CV-X-IF result interface towards the host CPU. It uses round-robin fair arbitration and a registered output stage. Accepted results are held stable until the CPU takes them. It sits between the coprocessor's execution units and the coprocessor result modport.

## Interface
Parameters:
- `NUM_SRC`, 4: number of result sources; legal range 2..16.
- `X_ID_WIDTH`, 4: instruction ID width; must match the interface.
- `X_HARTID_WIDTH`, 1: hart ID width.
- `X_RFW_WIDTH`, 32: writeback data width.
- `X_DUALWRITE`, 0: 0 gives a 1-bit `we`; 1 gives a 2-bit `we`.

Ports:
- `clk_i`  in  1  sole clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `src_valid_i`  in  `NUM_SRC`  per-source result valid.
- `src_ready_o`  out  `NUM_SRC`  per-source accept, one-hot or zero.
- `src_result_i`  in  `NUM_SRC` × `x_result_t`  per-source result payload (hartid, id, data, rd, we, exc, exccode, dbg, err).
- `result_valid_o`  out  1  CV-X-IF result valid.
- `result_ready_i`  in  1  CV-X-IF result ready from the CPU.
- `result_o`  out  `x_result_t`  CV-X-IF result payload.
- `grant_idx_o`  out  `$clog2(NUM_SRC)`  index of the source whose result currently occupies the output register; for debug and trace.

## Operation
- The output register is a single entry: `out_valid`, `out_result`, `out_idx`.
- `can_load` = !`out_valid` | `result_ready_i`.
- Round-robin pointer `rr_ptr` is the highest-priority source index. Priority order is `rr_ptr`, `rr_ptr`+1, … wrapping modulo `NUM_SRC`.
- Winner `g` is the first index in priority order with `src_valid_i[g]`=1.
- `src_ready_o[g]` = `can_load` and a winner exists. All other ready bits are 0.
- `src_ready_o` is combinational from `src_valid_i`, `out_valid`, `result_ready_i` and `rr_ptr`. There is no ready→valid loop inside the block.
- On accept (`src_valid_i[g]` & `src_ready_o[g]`):
  - `out_result` ← `src_result_i[g]`, `out_idx` ← `g`, `out_valid` ← 1.
  - `rr_ptr` ← (`g`+1) mod `NUM_SRC`.
- On drain with no new accept (`result_valid_o` & `result_ready_i`, no source valid): `out_valid` ← 0.
- `rr_ptr` changes only on an accept. With no valid source it holds.
- Payload is passed through unmodified, including `exc`, `err` and `dbg`. Sources carrying `exc`=1 get no priority boost.
- `result_o` is don't-care while `result_valid_o`=0. The implementation drives the register contents.

## Timing
- Reset (`rst_i`=1 at the edge): `out_valid`=0, `out_result`=0, `out_idx`=0, `rr_ptr`=0.
- During reset and the cycle after, `result_valid_o`=0, `result_o`=0 and `grant_idx_o`=0.
- `src_ready_o` is all-zero while `rst_i`=1.
- Reset mid-operation discards the held result with no handshake. Sources must not consider an unaccepted result delivered.
- Latency: source accept in cycle N gives `result_valid_o`=1 in cycle N+1.
- Throughput: one result per cycle when `result_ready_i` is held at 1.
- Back-pressure: while `result_valid_o`=1 and `result_ready_i`=0, `result_o` and `grant_idx_o` are stable and `src_ready_o`=0.
- Simultaneous drain and accept in one cycle: the register reloads and `result_valid_o` stays 1. There is no bubble.
- The output never deasserts `result_valid_o` without a handshake, per the CV-X-IF valid/ready rule.
- Wrap-around: winner `NUM_SRC`-1 sets `rr_ptr` to 0.
- Sources must keep valid and payload stable until ready. Violations are undefined. The bench checks them with assertions.

## Structure
- Shared package `xif_pkg` holds the `x_result_t` struct (parameterised widths via package parameters or a typedef wrapper), `NUM_SRC` limits, and the `$clog2` index width helper.
- One sub-module: `rr_arbiter`, a combinational round-robin priority picker. It takes `req`[N] and `ptr` and returns one-hot `gnt` plus `idx`. It is reused elsewhere for register-interface sharing.
- The top level holds the output register and pointer update.

## Test plan
- Reset: hold `rst_i`=1 for 3 cycles with all `src_valid_i`=1 → `src_ready_o`=0 and `result_valid_o`=0 throughout. After release, first grant goes to source 0.
- Fairness: all 4 sources continuously valid, `result_ready_i`=1 → grant sequence 0,1,2,3,0,1 with one result per cycle. `id` on `result_o` matches each source's ID one cycle later.
- Back-pressure: source 2 sends id=5 while `result_ready_i`=0 for 4 cycles → `result_o` holds id=5 and `grant_idx_o`=2, all `src_ready_o`=0. On ready=1 it drains and the next grant is issued the same cycle.
- Sparse requests: only source 3 valid, then source 1 → grants 3, then 1; `rr_ptr` wraps to 0 after the grant to 3.
- Payload passthrough: source 1 sends `exc`=1, `exccode`=6'd13, `we`=0, `data`=32'hDEADBEEF → identical fields on `result_o`.
- Reset mid-flight: assert `rst_i` while `result_valid_o`=1 and ready=0 → next cycle `result_valid_o`=0 and `rr_ptr`=0.
